fxp_divider_param: RTL and testbench

//   Iterative fixed-point divider producing q = a / b on WIDTH-bit operands with FRAC

---
 rtl/fxp_divider_param.sv | 140 ++++++++++++++
 tb/tb_fxp_divider_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_divider_param.sv
// rtl/fxp_divider_param.sv - iterative restoring fixed-point divider, one quotient bit per clock
// Start/busy/valid coprocessor with unsigned or two's-complement operands, saturation and dvz.
module fxp_divider_param #(
  parameter int WIDTH  = 10,
  parameter int FRAC   = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dvz,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);
  localparam int N   = WIDTH + FRAC;
  localparam int NP1 = N + 1;
  localparam int CW  = $clog2(N);
  localparam logic [N:0] LIM_U  = (NP1'(1) << WIDTH) - NP1'(1);
  localparam logic [N:0] LIM_SN = NP1'(1) << (WIDTH - 1);
  localparam logic [N:0] LIM_SP = LIM_SN - NP1'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [N-1:0]     quot_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q;
  logic             a_neg_q;
  logic             dvz_pend_q;
  logic [WIDTH-1:0] q_out_q;
  logic [WIDTH-1:0] r_out_q;
  logic             dvz_out_q;
  logic             ovf_out_q;
  logic             busy_q;
  logic             valid_q;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_d;
  logic [N-1:0]     quot_d;
  logic [N:0]       lim;
  logic             ovf_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] qdvz_d;

  always_comb begin
    a_abs  = (SIGNED && a_in[WIDTH-1]) ? -a_in : a_in;
    b_abs  = (SIGNED && b_in[WIDTH-1]) ? -b_in : b_in;
    // rem_sh < 2*div, so a set MSB in diff means the trial subtraction went negative
    rem_sh = {rem_q, quot_q[N-1]};
    diff   = rem_sh - {1'b0, div_q};
    rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quot_d = {quot_q[N-2:0], ~diff[WIDTH]};

    if (!SIGNED)    lim = LIM_U;
    else if (neg_q) lim = LIM_SN;
    else            lim = LIM_SP;
    ovf_d = {1'b0, quot_q} > lim;
    if (ovf_d) q_d = !SIGNED ? '1 : (neg_q ? MIN_NEG : MAX_POS);
    else       q_d = neg_q ? -quot_q[WIDTH-1:0] : quot_q[WIDTH-1:0];
    qdvz_d = !SIGNED ? '1 : (a_neg_q ? MIN_NEG : MAX_POS);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= IDLE;
      quot_q     <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      a_neg_q    <= 1'b0;
      dvz_pend_q <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
      dvz_out_q  <= 1'b0;
      ovf_out_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            quot_q     <= N'(a_abs) << FRAC;
            div_q      <= b_abs;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= SIGNED && (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            a_neg_q    <= SIGNED && a_in[WIDTH-1];
            dvz_pend_q <= (b_in == '0);
            busy_q     <= (b_in != '0);
            state_q    <= (b_in == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b1;
          if (dvz_pend_q) begin
            q_out_q   <= qdvz_d;
            r_out_q   <= '0;
            dvz_out_q <= 1'b1;
            ovf_out_q <= 1'b0;
          end else begin
            q_out_q   <= q_d;
            r_out_q   <= rem_q;
            dvz_out_q <= 1'b0;
            ovf_out_q <= ovf_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign q_out = q_out_q;
  assign r_out = r_out_q;
  assign dvz   = dvz_out_q;
  assign ovf   = ovf_out_q;
  assign busy  = busy_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_fxp_divider_param.sv
// tb/tb_fxp_divider_param.sv - self-checking bench for fxp_divider_param (unsigned and signed)
module tb_fxp_divider_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       sclr;
  logic       start_u, start_s;
  logic [9:0] a_u, b_u, a_s, b_s;
  logic [9:0] q_u, r_u, q_s, r_s;
  logic       dvz_u, ovf_u, busy_u, valid_u;
  logic       dvz_s, ovf_s, busy_s, valid_s;

  fxp_divider_param #(.WIDTH(10), .FRAC(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .sclr(sclr), .start(start_u), .a_in(a_u), .b_in(b_u),
    .q_out(q_u), .r_out(r_u), .dvz(dvz_u), .ovf(ovf_u), .busy(busy_u), .valid(valid_u)
  );

  fxp_divider_param #(.WIDTH(10), .FRAC(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .sclr(sclr), .start(start_s), .a_in(a_s), .b_in(b_s),
    .q_out(q_s), .r_out(r_s), .dvz(dvz_s), .ovf(ovf_s), .busy(busy_s), .valid(valid_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  bit         sel;
  logic [9:0] q_m, r_m;
  logic       dvz_m, ovf_m, busy_m, valid_m;
  assign q_m     = sel ? q_s     : q_u;
  assign r_m     = sel ? r_s     : r_u;
  assign dvz_m   = sel ? dvz_s   : dvz_u;
  assign ovf_m   = sel ? ovf_s   : ovf_u;
  assign busy_m  = sel ? busy_s  : busy_u;
  assign valid_m = sel ? valid_s : valid_u;

  logic [9:0] got_q, got_r;
  logic       got_dvz, got_ovf, got_busy;
  int         got_lat;

  // Reference: exact integer arithmetic on the real values, then the saturation rules.
  function automatic void ref_div(input bit sg, input logic [9:0] a, input logic [9:0] b,
                                  output logic [9:0] eq, output logic [9:0] er,
                                  output logic edz, output logic eov);
    longint sa, sb, ma, mb, qq, rr;
    bit neg;
    sa = (sg && a[9]) ? longint'(a) - 1024 : longint'(a);
    sb = (sg && b[9]) ? longint'(b) - 1024 : longint'(b);
    if (b == 10'd0) begin
      edz = 1'b1; eov = 1'b0; er = 10'd0;
      eq  = !sg ? 10'h3FF : (sa >= 0 ? 10'h1FF : 10'h200);
      return;
    end
    ma  = sa < 0 ? -sa : sa;
    mb  = sb < 0 ? -sb : sb;
    qq  = (ma * 16) / mb;
    rr  = (ma * 16) % mb;
    neg = (sa < 0) != (sb < 0);
    edz = 1'b0;
    er  = 10'(rr);
    if (!sg) begin
      eov = qq > 1023; eq = eov ? 10'h3FF : 10'(qq);
    end else if (!neg) begin
      eov = qq > 511;  eq = eov ? 10'h1FF : 10'(qq);
    end else begin
      eov = qq > 512;  eq = eov ? 10'h200 : 10'(1024 - qq);
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one request right now (caller is #1 after an edge) and waits for valid.
  task automatic run_div(input bit sg, input logic [9:0] a, input logic [9:0] b);
    sel = sg;
    if (sg) begin start_s = 1'b1; a_s = a; b_s = b; end
    else    begin start_u = 1'b1; a_u = a; b_u = b; end
    @(posedge clk); #1;
    start_u = 1'b0; start_s = 1'b0;
    got_busy = busy_m;
    a_u = 10'($urandom); b_u = 10'($urandom);
    a_s = 10'($urandom); b_s = 10'($urandom);
    got_lat = 0;
    while (!valid_m && got_lat < 40) begin
      @(posedge clk); #1;
      got_lat++;
    end
    got_q = q_m; got_r = r_m; got_dvz = dvz_m; got_ovf = ovf_m;
  endtask

  task automatic test_reset;
    sclr = 1'b1; start_u = 1'b0; start_s = 1'b0;
    a_u = '0; b_u = '0; a_s = '0; b_s = '0;
    idle(3);
    n_cmp++;
    if ({q_u, r_u, dvz_u, ovf_u, busy_u, valid_u} !== 24'd0) begin
      n_bad++; $display("FAIL reset_u: got %h required 0", {q_u, r_u, dvz_u, ovf_u, busy_u, valid_u});
    end
    n_cmp++;
    if ({q_s, r_s, dvz_s, ovf_s, busy_s, valid_s} !== 24'd0) begin
      n_bad++; $display("FAIL reset_s: got %h required 0", {q_s, r_s, dvz_s, ovf_s, busy_s, valid_s});
    end
    sclr = 1'b0;
    idle(1);
  endtask

  task automatic test_directed;
    run_div(1'b0, 10'b0001010000, 10'b0000100000);
    n_cmp++;
    if ({got_q, got_r, got_dvz, got_ovf} !== {10'b0000101000, 10'd0, 2'b00}) begin
      n_bad++; $display("FAIL div_5_2: got q=%b r=%b dvz=%b ovf=%b required q=0000101000 r=0 flags 0", got_q, got_r, got_dvz, got_ovf);
    end
    n_cmp++;
    if (got_lat !== 15) begin n_bad++; $display("FAIL latency: got %0d required 15", got_lat); end
    n_cmp++;
    if (got_busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b required 1", got_busy); end

    run_div(1'b0, 10'b0100100000, 10'b0001100000);
    n_cmp++;
    if (got_q !== 10'b0000110000 || got_lat !== 15) begin
      n_bad++; $display("FAIL back_to_back: got q=%b lat=%0d required q=0000110000 lat=15", got_q, got_lat);
    end
    idle(2);

    run_div(1'b0, 10'b0000010000, 10'b0000110000);
    n_cmp++;
    if (got_q !== 10'b0000000101 || got_r !== 10'b0000010000) begin
      n_bad++; $display("FAIL div_1_3: got q=%b r=%b required q=0000000101 r=0000010000", got_q, got_r);
    end
    idle(2);

    run_div(1'b0, 10'b1111000000, 10'b0000000001);
    n_cmp++;
    if (got_q !== 10'h3FF || got_ovf !== 1'b1 || got_dvz !== 1'b0) begin
      n_bad++; $display("FAIL ovf_u: got q=%h ovf=%b dvz=%b required q=3ff ovf=1 dvz=0", got_q, got_ovf, got_dvz);
    end
    idle(2);

    run_div(1'b0, 10'b0001010000, 10'd0);
    n_cmp++;
    if ({got_q, got_r, got_dvz, got_ovf} !== {10'h3FF, 10'd0, 2'b10} || got_lat !== 1 || got_busy !== 1'b0) begin
      n_bad++; $display("FAIL dvz_u: got q=%h r=%h dvz=%b ovf=%b lat=%0d busy=%b required q=3ff r=0 dvz=1 ovf=0 lat=1 busy=0",
                        got_q, got_r, got_dvz, got_ovf, got_lat, got_busy);
    end
    idle(2);

    run_div(1'b1, 10'b1110110000, 10'b0000100000);
    n_cmp++;
    if (got_q !== 10'b1111011000 || got_ovf !== 1'b0) begin
      n_bad++; $display("FAIL signed_neg: got q=%b ovf=%b required q=1111011000 ovf=0", got_q, got_ovf);
    end
    idle(2);

    run_div(1'b1, 10'b1110110000, 10'd0);
    n_cmp++;
    if (got_q !== 10'h200 || got_dvz !== 1'b1 || got_lat !== 1) begin
      n_bad++; $display("FAIL dvz_s_neg: got q=%h dvz=%b lat=%0d required q=200 dvz=1 lat=1", got_q, got_dvz, got_lat);
    end
    idle(2);
  endtask

  task automatic test_busy_ignore;
    int lat;
    sel = 1'b0;
    start_u = 1'b1; a_u = 10'b0001010000; b_u = 10'b0000100000;
    @(posedge clk); #1;
    a_u = 10'b0000010000; b_u = 10'b0000110000;
    lat = 0;
    while (!valid_u && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) start_u = 1'b0;
    end
    start_u = 1'b0;
    n_cmp++;
    if (q_u !== 10'b0000101000 || lat !== 15) begin
      n_bad++; $display("FAIL start_while_busy: got q=%b lat=%0d required q=0000101000 lat=15", q_u, lat);
    end
    idle(2);
  endtask

  task automatic test_sclr_abort;
    int seen;
    start_u = 1'b1; a_u = 10'b0001010000; b_u = 10'b0000100000;
    @(posedge clk); #1;
    start_u = 1'b0;
    idle(7);
    sclr = 1'b1;
    idle(1);
    sclr = 1'b0;
    n_cmp++;
    if ({q_u, r_u, dvz_u, ovf_u, busy_u, valid_u} !== 24'd0) begin
      n_bad++; $display("FAIL sclr_abort: got %h required 0", {q_u, r_u, dvz_u, ovf_u, busy_u, valid_u});
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid_u) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL sclr_no_valid: got %0d pulses required 0", seen); end
  endtask

  task automatic test_sclr_start;
    int seen;
    sclr = 1'b1; start_u = 1'b1; a_u = 10'b0001010000; b_u = 10'b0000100000;
    idle(1);
    sclr = 1'b0; start_u = 1'b0;
    n_cmp++;
    if (busy_u !== 1'b0) begin n_bad++; $display("FAIL sclr_start_busy: got %b required 0", busy_u); end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid_u || busy_u) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL sclr_start_idle: got %0d active cycles required 0", seen); end
  endtask

  task automatic test_random;
    logic [9:0] a, b, eq, er;
    logic       edz, eov;
    for (int i = 0; i < 30; i++) begin
      for (int s = 0; s < 2; s++) begin
        a = 10'($urandom);
        case ($urandom_range(0, 5))
          0:       b = 10'd0;
          1:       b = 10'($urandom_range(1, 3));
          default: b = 10'($urandom);
        endcase
        ref_div(s[0], a, b, eq, er, edz, eov);
        run_div(s[0], a, b);
        n_cmp++;
        if ({got_q, got_r, got_dvz, got_ovf} !== {eq, er, edz, eov} || got_lat !== (b == 10'd0 ? 1 : 15)) begin
          n_bad++;
          $display("FAIL random sg=%0d a=%h b=%h: got q=%h r=%h dvz=%b ovf=%b lat=%0d required q=%h r=%h dvz=%b ovf=%b",
                   s, a, b, got_q, got_r, got_dvz, got_ovf, got_lat, eq, er, edz, eov);
        end
        if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    sel = 1'b0;
    test_reset;
    test_directed;
    test_busy_ignore;
    test_sclr_abort;
    test_sclr_start;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
